// File: rtl/lcd_pkg.sv
// ============================================================================
// lcd_pkg: shared command codes and scheduler state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

  localparam logic [3:0] CMD_WRITE = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_MAX   = 4'd5;
  localparam logic [3:0] CMD_MIN   = 4'd6;
  localparam logic [3:0] CMD_AVG   = 4'd7;
  localparam logic [3:0] CMD_LAST  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_e;

  function automatic logic cmd_legal(input logic [3:0] code);
    return code <= CMD_LAST;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_cmd_fifo.sv
// ============================================================================
// lcd_cmd_fifo: small per-requester command FIFO with registered occupancy.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  // A push on a full FIFO is refused even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ONE_PTR;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ONE_PTR;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + ONE_CNT;
        2'b01:   count_q <= count_q - ONE_CNT;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_cmd_sched.sv
// ============================================================================
// lcd_cmd_sched: two-requester round-robin command scheduler for the LCD
// controller, issuing one command at a time under the busy handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_cmd_sched
  import lcd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ACK_TO = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a_cmd,
  input  logic       a_valid,
  output logic       a_ready,
  output logic       a_cmpl,
  output logic       a_rej,
  input  logic [3:0] b_cmd,
  input  logic       b_valid,
  output logic       b_ready,
  output logic       b_cmpl,
  output logic       b_rej,
  output logic [3:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  input  logic       lcd_busy,
  output logic       owner,
  output logic       timeout
);

  localparam int CW = $clog2(ACK_TO + 1);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TO - 1);
  localparam logic [CW-1:0] ONE_CW   = CW'(1);

  sched_state_e  state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          owner_q, owner_d;
  logic          rr_b_q, rr_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          a_cmpl_q, a_cmpl_d, b_cmpl_q, b_cmpl_d;
  logic          timeout_q, timeout_d;
  logic          a_rej_q, b_rej_q;

  logic          a_full, a_empty, b_full, b_empty;
  logic [3:0]    a_dout, b_dout;
  logic          a_push, b_push, a_pop, b_pop, sel_b, done;

  assign a_ready = !a_full;
  assign b_ready = !b_full;
  assign a_push  = a_valid && !a_full && cmd_legal(a_cmd);
  assign b_push  = b_valid && !b_full && cmd_legal(b_cmd);

  lcd_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo_a (
    .clk(clk), .rst(rst), .push_i(a_push), .din_i(a_cmd), .pop_i(a_pop),
    .full_o(a_full), .empty_o(a_empty), .dout_o(a_dout)
  );

  lcd_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo_b (
    .clk(clk), .rst(rst), .push_i(b_push), .din_i(b_cmd), .pop_i(b_pop),
    .full_o(b_full), .empty_o(b_empty), .dout_o(b_dout)
  );

  // rr_b_q set means B goes first when both ports have work.
  assign sel_b = !b_empty && (a_empty || rr_b_q);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    owner_d   = owner_q;
    rr_b_d    = rr_b_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    a_pop     = 1'b0;
    b_pop     = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!lcd_busy && (!a_empty || !b_empty)) begin
          a_pop   = !sel_b;
          b_pop   = sel_b;
          cmd_d   = sel_b ? b_dout : a_dout;
          owner_d = sel_b;
          rr_b_d  = !sel_b;
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (lcd_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == ACK_LAST) begin
          timeout_d = 1'b1;
          done      = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE_CW;
        end
      end
      ST_WAIT_DONE: begin
        if (!lcd_busy) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    a_cmpl_d = done && !owner_q;
    b_cmpl_d = done && owner_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      owner_q   <= 1'b0;
      rr_b_q    <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      a_cmpl_q  <= 1'b0;
      b_cmpl_q  <= 1'b0;
      timeout_q <= 1'b0;
      a_rej_q   <= 1'b0;
      b_rej_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      owner_q   <= owner_d;
      rr_b_q    <= rr_b_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      a_cmpl_q  <= a_cmpl_d;
      b_cmpl_q  <= b_cmpl_d;
      timeout_q <= timeout_d;
      a_rej_q   <= a_valid && !a_full && !cmd_legal(a_cmd);
      b_rej_q   <= b_valid && !b_full && !cmd_legal(b_cmd);
    end
  end

  assign lcd_cmd       = cmd_q;
  assign lcd_cmd_valid = valid_q;
  assign owner         = owner_q;
  assign a_cmpl        = a_cmpl_q;
  assign b_cmpl        = b_cmpl_q;
  assign timeout       = timeout_q;
  assign a_rej         = a_rej_q;
  assign b_rej         = b_rej_q;

endmodule

`default_nettype wire

// File: doc/lcd_cmd_sched.md
Name: lcd_cmd_sched

Overview:
Command scheduler in front of the LCD image-processing controller. It queues commands from two independent requesters (A = host, B = auxiliary sequencer) in per-port FIFOs and arbitrates them round-robin. It issues one command at a time on the controller's cmd/cmd_valid interface, following the controller's busy handshake. It reports per-requester completion and rejection pulses.

Parameters:
DEPTH, 4, entries per requester FIFO (power of 2, 2..16)
ACK_TO, 4, cycles to wait for lcd_busy to rise after issue before declaring a timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
a_cmd  in  4  requester A command code
a_valid  in  1  requester A command strobe
a_ready  out  1  A FIFO not full
a_cmpl  out  1  one-cycle pulse: an A command finished
a_rej  out  1  one-cycle pulse: an A command was rejected (illegal code)
b_cmd  in  4  requester B command code
b_valid  in  1  requester B command strobe
b_ready  out  1  B FIFO not full
b_cmpl  out  1  one-cycle pulse: a B command finished
b_rej  out  1  one-cycle pulse: a B command was rejected
lcd_cmd  out  4  command to the controller
lcd_cmd_valid  out  1  one-cycle issue strobe
lcd_busy  in  1  controller busy
owner  out  1  source of the in-flight or last command (0=A, 1=B)
timeout  out  1  one-cycle pulse: ACK_TO expired

Behaviour:
- Reset (rst=0, async): all outputs 0; FIFOs empty; rr pointer favours A; state IDLE. a_ready/b_ready read 1 after reset.
- Enqueue: push when x_valid && x_ready. Codes 0..7 are legal. Codes 8..15 are not stored; x_rej pulses on the next cycle. x_valid while full: push ignored, no rej. The requester must hold the command.
- x_ready = !full, registered from FIFO count. Simultaneous push and pop on a full FIFO: push is refused (ready was 0).
- FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE: if lcd_busy==0 and any FIFO is non-empty, pick a port. With both non-empty, pick the port != last owner. Pop the head into a cmd register, set owner, go to ISSUE. lcd_busy high in IDLE (controller's post-reset image load) blocks issue.
- ISSUE: lcd_cmd_valid=1 for exactly one cycle with lcd_cmd = cmd register. Go to WAIT_ACK with the ack counter cleared.
- WAIT_ACK: lcd_busy==1 -> WAIT_DONE. Otherwise the counter increments. When the counter reaches ACK_TO: pulse timeout, pulse x_cmpl for owner, go to IDLE. The command is not retried.
- WAIT_DONE: on the first cycle with lcd_busy==0, pulse x_cmpl for owner and go to IDLE. Earliest re-issue is the following cycle.
- Issue-to-issue minimum spacing: 4 cycles (IDLE, ISSUE, WAIT_ACK, WAIT_DONE).
- lcd_cmd holds its last value outside ISSUE. lcd_cmd_valid is registered.
- Reset mid-command: FIFO contents and in-flight state are discarded. No cmpl is emitted for the in-flight command.
- FIFO pointers are log2(DEPTH) bits and wrap. The count is log2(DEPTH)+1 bits.
- Command 0 (write-out) is scheduled like any other command. Its WAIT_DONE spans the full 64-word write-back.

Decomposition:
- Shared package lcd_pkg: command codes CMD_WRITE=0, CMD_UP=1, CMD_DOWN=2, CMD_LEFT=3, CMD_RIGHT=4, CMD_MAX=5, CMD_MIN=6, CMD_AVG=7, CMD_LAST=7; scheduler state encoding.
- One sub-module, lcd_cmd_fifo (parameter DEPTH, WIDTH=4; push/pop/full/empty/dout), instantiated twice.

Test Plan:
- Post-reset hold: lcd_busy=1 for 70 cycles, A pushes cmd 5 -> no lcd_cmd_valid until busy falls; then lcd_cmd=5, lcd_cmd_valid for 1 cycle; a_cmpl one cycle after busy falls again.
- Round-robin: A pushes 1,2 and B pushes 3,4 at the same time, lcd_busy model 1 cycle after issue for 2 cycles -> issue order 1,3,2,4 with owner 0,1,0,1.
- Full/backpressure: with busy held high, A pushes DEPTH+1 commands -> a_ready=0 after DEPTH pushes, the extra push is dropped, and exactly DEPTH commands are later issued.
- Illegal code: B pushes 4'd9 -> b_rej pulse, no FIFO entry, no issue.
- Timeout: lcd_busy stuck 0 after issue of cmd 7 -> timeout and a_cmpl pulse ACK_TO cycles after the ack wait starts; the next queued command then issues normally.
- Async reset mid-WAIT_DONE with 2 entries queued -> outputs 0 immediately, nothing issued after release until a new push.
